// File: rtl/pipe_run_monitor.sv
// Run-control monitor: flags end-of-run or fault, freezes cause/address, halts after drain.
// Optional MON_CYCLE_COUNT_EN adds the run_cycles output.
module pipe_run_monitor #(
    parameter int XLEN         = 32,
    parameter int IMEM_AW      = 12,
    parameter int DMEM_AW      = 12,
    parameter int TIMEOUT      = 100,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 1,
    parameter int WATCH_TARGET = 10673
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            exception,
    input  logic [XLEN-1:0] pc,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_addr,
    input  logic            dmem_wr_valid,
    input  logic [XLEN-1:0] dmem_wr_addr,
    input  logic            dmem_rd_valid,
    input  logic [XLEN-1:0] dmem_rd_addr,
    input  logic [XLEN-1:0] watch_value,
`ifdef MON_CYCLE_COUNT_EN
    output logic [31:0]     run_cycles,
`endif
    output logic            trig,
    output logic            halt,
    output logic [2:0]      halt_cause,
    output logic [XLEN-1:0] fault_addr,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] prev_pc;
    logic [DW-1:0]   drain_cnt;

    logic            imem_oor;
    logic            wr_oor;
    logic            rd_oor;
    logic            watch_hit;
    logic            timeout_hit;
    logic            ev_any;
    logic [2:0]      ev_cause;
    logic [XLEN-1:0] ev_addr;

    assign imem_oor    = imem_valid && (imem_addr[XLEN-1:IMEM_AW] != '0);
    assign wr_oor      = dmem_wr_valid && (dmem_wr_addr[XLEN-1:DMEM_AW] != '0);
    assign rd_oor      = dmem_rd_valid && (dmem_rd_addr[XLEN-1:DMEM_AW] != '0);
    assign watch_hit   = watch_value == XLEN'(WATCH_TARGET);
    assign timeout_hit = stall_count > CNT_W'(TIMEOUT);

    // Fixed priority: lowest cause code wins when several fire together.
    always_comb begin
        ev_any   = 1'b1;
        ev_cause = 3'd0;
        ev_addr  = pc;
        if (exception) begin
            ev_cause = 3'd1;
        end else if (imem_oor) begin
            ev_cause = 3'd2;
            ev_addr  = imem_addr;
        end else if (wr_oor) begin
            ev_cause = 3'd3;
            ev_addr  = dmem_wr_addr;
        end else if (rd_oor) begin
            ev_cause = 3'd3;
            ev_addr  = dmem_rd_addr;
        end else if (watch_hit) begin
            ev_cause = 3'd4;
        end else if (timeout_hit) begin
            ev_cause = 3'd5;
        end else begin
            ev_any = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev_pc     <= '0;
            drain_cnt   <= '0;
            trig        <= 1'b0;
            halt        <= 1'b0;
            halt_cause  <= 3'd0;
            fault_addr  <= '0;
            stall_count <= '0;
`ifdef MON_CYCLE_COUNT_EN
            run_cycles  <= '0;
`endif
        end else begin
            prev_pc <= pc;
            trig    <= 1'b0;
`ifdef MON_CYCLE_COUNT_EN
            if ((state == RUN || state == DRAIN) && run_cycles != '1)
                run_cycles <= run_cycles + 32'd1;
`endif
            unique case (state)
                IDLE: begin
                    stall_count <= '0;
                    if (!stall)
                        state <= RUN;
                end
                RUN: begin
                    if (pc != prev_pc)
                        stall_count <= '0;
                    else if (!stall && stall_count != '1)
                        stall_count <= stall_count + 1'b1;
                    if (ev_any) begin
                        trig       <= 1'b1;
                        halt_cause <= ev_cause;
                        fault_addr <= ev_addr;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                HALT: begin
                end
            endcase
        end
    end

endmodule
